// File: rtl/aud_recorder.sv
// ---------------------------------------------------------------------------
// aud_recorder
// I2S receive-side deserializer. Samples the codec ADC bit stream on BCLK,
// extracts the 16-bit left-channel word of each LRC frame and presents it,
// with a sequential sample address, as a one-cycle write strobe for the SRAM
// write logic. Start / pause / stop pulses come from the recording FSM.
//
// Parameters
//   ADDR_W     width of the sample address
//   MAX_ADDR   address of the last storable sample; recording ends after it
//
// Ports
//   i_clk       BCLK from codec, rising-edge active
//   i_rst_n     asynchronous active-low reset
//   i_lrc       ADCLRCK, 0 = left, 1 = right
//   i_start     start (from IDLE) / resume (from PAUSE), 1-cycle pulse
//   i_pause     pause request, 1-cycle pulse
//   i_stop      stop request, 1-cycle pulse
//   i_adc_data  ADCDAT serial bit, MSB first
//   o_address   address of the current/next sample
//   o_data      last captured sample (two's complement)
//   o_valid     1-cycle write strobe for o_data/o_address
//   o_full      set after sample MAX_ADDR was written, cleared by next start
//   o_state     current state encoding
// ---------------------------------------------------------------------------
module aud_recorder #(
    parameter int unsigned       ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_adc_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [15:0]       o_data,
    output logic              o_valid,
    output logic              o_full,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_REC   = 3'd2,
        S_PAUSE = 3'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic              r_valid;
    logic              r_full;
    logic [3:0]        r_cnt;
    logic              r_hi_seen;
    logic [14:0]       r_shift;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       w_data_nxt;
    logic              w_valid_nxt;
    logic              w_full_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_hi_nxt;
    logic [14:0]       w_shift_nxt;

    // Coincident control pulses resolve as stop > pause > start.
    logic w_stop, w_pause, w_start;
    assign w_stop  = i_stop;
    assign w_pause = i_pause & ~i_stop;
    assign w_start = i_start & ~i_pause & ~i_stop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
            r_cnt     <= 4'd15;
            r_hi_seen <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_full    <= w_full_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi_seen <= w_hi_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_full_nxt  = r_full;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi_seen;
        w_shift_nxt = r_shift;

        // Advance the address the cycle after a write. The write that fills
        // the buffer sets r_full together with r_valid, which blocks this and
        // leaves the address parked at MAX_ADDR.
        if (r_valid && !r_full)
            w_addr_nxt = r_addr + 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_WAIT;
                    w_addr_nxt  = '0;
                    w_full_nxt  = 1'b0;
                    w_hi_nxt    = 1'b0;
                end
            end

            // Wait for a right->left LRC transition. The first low cycle after
            // a high one is the I2S delay slot; its data bit is dropped.
            S_WAIT: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (i_lrc) begin
                    w_hi_nxt = 1'b1;
                end else if (r_hi_seen) begin
                    w_state_nxt = S_REC;
                    w_cnt_nxt   = 4'd15;
                    w_hi_nxt    = 1'b0;
                end
            end

            // Shift in 16 bits; a stop/pause on any of them, including the
            // last, throws the partial word away with no write.
            S_REC: begin
                if (w_stop || w_pause) begin
                    w_state_nxt = w_stop ? S_IDLE : S_PAUSE;
                    w_cnt_nxt   = 4'd15;
                end else begin
                    w_shift_nxt = {r_shift[13:0], i_adc_data};
                    w_cnt_nxt   = r_cnt - 4'd1;
                    if (r_cnt == 4'd0) begin
                        w_data_nxt  = {r_shift, i_adc_data};
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = 4'd15;
                        w_hi_nxt    = 1'b0;
                        if (r_addr == MAX_ADDR) begin
                            w_state_nxt = S_IDLE;
                            w_full_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
            end

            S_PAUSE: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_start) begin
                    w_state_nxt = S_WAIT;
                    w_hi_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_address = r_addr;
    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_full    = r_full;
    assign o_state   = r_state;

endmodule

// File: doc/aud_recorder.md
# aud_recorder

I2S receive-side deserializer for the audio path; the capture counterpart of the DAC playback serializer. It samples the codec ADC bit stream on BCLK, extracts the 16-bit left-channel word of every LRC frame, and presents each word with a sequential storage address to the SRAM write logic. Start, pause and stop are controlled by the top-level recording FSM.

## Interface
- ADDR_W, 20, width of the sample address.
- MAX_ADDR, 2**ADDR_W-1, address of the last storable sample; recording ends after this sample is written.

- i_clk  in  1  BCLK from codec; all registers update on the rising edge.
- i_rst_n  in  1  one clock; reset is asynchronous and active-low.
- i_lrc  in  1  ADCLRCK; 0 = left channel, 1 = right channel.
- i_start  in  1  start (from IDLE) or resume (from PAUSE); 1-cycle pulse.
- i_pause  in  1  pause request; 1-cycle pulse.
- i_stop  in  1  stop request; 1-cycle pulse.
- i_adc_data  in  1  ADCDAT serial bit, MSB first.
- o_address  out  ADDR_W  address for the current/next sample.
- o_data  out  16  last captured sample, two's complement.
- o_valid  out  1  1-cycle strobe: o_data/o_address form a write.
- o_full  out  1  high after sample MAX_ADDR was written; cleared by next start from IDLE.
- o_state  out  3  current state encoding.

## Operation
- States: S_IDLE=0, S_WAIT=1, S_REC=2, S_PAUSE=3.
- Control priority when pulses coincide: i_stop > i_pause > i_start.
- S_IDLE: i_start -> S_WAIT, o_address <= 0, o_full <= 0, hi_seen <= 0. Other inputs ignored.
- S_WAIT: i_lrc==1 sets hi_seen. i_lrc==0 with hi_seen==1 -> S_REC, bit counter <= 15, hi_seen <= 0; the current cycle is the I2S delay slot and its i_adc_data is discarded. Entering with i_lrc already low therefore waits for a full right half-frame before capturing.
- S_REC: each cycle shift i_adc_data into shift register, decrement counter. On the cycle counter==0 (16th bit): o_data <= {shift[14:0], i_adc_data}, o_valid <= 1, -> S_WAIT (hi_seen 0), or -> S_IDLE with o_full <= 1 when o_address==MAX_ADDR.
- The cycle after o_valid: o_address <= o_address+1, unless o_full was just set (address saturates at MAX_ADDR, never wraps).
- Right-channel bits (i_lrc==1) are never captured.
- i_pause in S_WAIT/S_REC -> S_PAUSE; partial word discarded, o_data unchanged, o_address kept.
- S_PAUSE: i_start -> S_WAIT with hi_seen <= 0, o_address kept (resume).
- i_stop in any non-IDLE state -> S_IDLE; partial word discarded, o_address kept, no o_valid.
- A stop/pause arriving on the 16th-bit cycle takes priority: no o_valid, word discarded.

## Timing
- Reset values: state S_IDLE, o_address 0, o_data 0, o_valid 0, o_full 0, o_state 0, counter 15, hi_seen 0, shift 0.
- Asynchronous reset mid-word aborts immediately; no o_valid follows.
- Latency: o_valid asserted at the rising edge that samples the LSB, i.e. 17 BCLK edges after the first edge seeing i_lrc low (1 delay slot + 16 bits).
- o_valid high exactly one cycle; o_data holds until the next capture; o_address equals the sample index while o_valid is high and changes the following cycle.
- Minimum 32 BCLK per LRC frame assumed by the codec config; consecutive o_valid separated by one full frame.

## Test plan
- Basic capture: start, one frame with delay-slot bit 1 then 16'hA5C3 on left -> o_valid once, o_data=16'hA5C3, o_address=0, then o_address=1.
- Channel/alignment: start while i_lrc low mid-left-half, right half carries 16'hFFFF -> no capture until next left half; next left word 16'h8001 -> o_data=16'h8001 (right data and delay slot ignored).
- Pause/resume: pause after 8 left bits -> S_PAUSE, no o_valid, o_address unchanged; start, next word 16'h1234 -> o_data=16'h1234 at same address.
- Stop priority: i_stop and i_pause on the 16th-bit cycle -> S_IDLE, no o_valid; later start -> o_address=0.
- Full: MAX_ADDR=2, three frames 16'h0001/0002/0003 -> o_valid at addresses 0,1,2, then o_full=1, S_IDLE, o_address stays 2; fourth frame ignored.
- Reset mid-word after 5 bits -> all outputs at reset values, no o_valid; recording resumes only after new start.
